// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: arbitrates single-word read/write requests and
// sequences Address/nOE/nWE/IO with programmable read wait and write pulse width.
`timescale 1ns/1ps
module sram_ctrl #(
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        rd_req,
    input  logic [17:0] rd_addr,
    output logic        rd_ack,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        wr_req,
    input  logic [17:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    output logic        busy,
    output logic [17:0] Address,
    output logic        nWE,
    output logic        nOE,
    inout  wire  [15:0] IO
);

    typedef enum logic [2:0] {
        IDLE,
        R_ADDR,
        R_TURN,
        W_SETUP,
        W_PULSE,
        W_HOLD
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_PULSE - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_last_wr;
    logic        r_rd_ack;
    logic        r_wr_ack;
    logic        r_rd_valid;
    logic        r_nwe;
    logic        r_noe;
    logic        r_io_en;
    logic [17:0] r_addr;
    logic [15:0] r_rd_data;
    logic [15:0] r_wdata;
    logic        w_grant_rd;
    logic        w_grant_wr;
    logic        w_capture;

    // Round-robin: on a tie the type not granted last wins.
    always_comb begin
        w_next     = r_state;
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_req && (!wr_req || r_last_wr)) begin
                    w_grant_rd = 1'b1;
                    w_next     = R_ADDR;
                end else if (wr_req) begin
                    w_grant_wr = 1'b1;
                    w_next     = W_SETUP;
                end
            end
            R_ADDR:  if (r_cnt == 4'd0) w_next = R_TURN;
            R_TURN:  w_next = IDLE;
            W_SETUP: w_next = W_PULSE;
            W_PULSE: if (r_cnt == 4'd0) w_next = W_HOLD;
            W_HOLD:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_capture = (r_state == R_ADDR) && (r_cnt == 4'd0);

    // Strobes are registered from the next state so they change with the state itself.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_last_wr  <= 1'b1;
            r_rd_ack   <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_nwe      <= 1'b1;
            r_noe      <= 1'b1;
            r_io_en    <= 1'b0;
            r_addr     <= 18'd0;
            r_rd_data  <= 16'd0;
        end else begin
            r_state    <= w_next;
            r_rd_ack   <= w_grant_rd;
            r_wr_ack   <= w_grant_wr;
            r_rd_valid <= w_capture;
            r_nwe      <= (w_next != W_PULSE);
            r_noe      <= (w_next != R_ADDR);
            r_io_en    <= (w_next == W_SETUP) || (w_next == W_PULSE) || (w_next == W_HOLD);
            if (w_grant_rd) begin
                r_addr    <= rd_addr;
                r_last_wr <= 1'b0;
            end else if (w_grant_wr) begin
                r_addr    <= wr_addr;
                r_last_wr <= 1'b1;
            end
            if (w_capture) r_rd_data <= IO;
            // Counter is loaded as each timed state is entered and saturates at zero.
            if (w_grant_rd) r_cnt <= RD_LOAD;
            else if (r_state == W_SETUP) r_cnt <= WR_LOAD;
            else if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_grant_wr) r_wdata <= wr_data;
    end

    assign IO       = r_io_en ? r_wdata : 'z;
    assign rd_ack   = r_rd_ack;
    assign wr_ack   = r_wr_ack;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign busy     = (r_state != IDLE);
    assign Address  = r_addr;
    assign nWE      = r_nwe;
    assign nOE      = r_noe;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: directed protocol steps plus randomized mixed traffic against
// a word-array reference memory and a round-robin grant model.
`timescale 1ns/1ps
module tb_sram_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        rd_req, wr_req;
    logic [17:0] rd_addr, wr_addr;
    logic [15:0] wr_data;
    logic        rd_ack, wr_ack, rd_valid, busy, nWE, nOE;
    logic [15:0] rd_data;
    logic [17:0] Address;
    wire  [15:0] IO;

    logic        rd_req2, wr_req2;
    logic [17:0] rd_addr2, wr_addr2;
    logic [15:0] wr_data2;
    logic        rd_ack2, wr_ack2, rd_valid2, busy2, nWE2, nOE2;
    logic [15:0] rd_data2;
    logic [17:0] Address2;
    wire  [15:0] IO2;

    bit   [15:0] sram    [0:262143];
    bit   [15:0] ref_mem [0:262143];
    logic [15:0] sram2;

    int          vectors = 0;
    int          errors  = 0;
    bit          m_last_wr;
    logic [17:0] exp_addr;
    logic [15:0] exp_wdata;

    always #7.8125 CLK = ~CLK;

    sram_ctrl u_dut (
        .CLK(CLK), .nRST(nRST),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .Address(Address), .nWE(nWE), .nOE(nOE), .IO(IO)
    );

    sram_ctrl #(.RD_WAIT(3), .WR_PULSE(2)) u_dut2 (
        .CLK(CLK), .nRST(nRST),
        .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_ack(rd_ack2), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ack(wr_ack2),
        .busy(busy2), .Address(Address2), .nWE(nWE2), .nOE(nOE2), .IO(IO2)
    );

    // Behavioural asynchronous SRAMs: drive on nOE low, store while nWE low.
    assign IO  = (!nOE)  ? sram[Address] : 16'bz;
    assign IO2 = (!nOE2) ? sram2         : 16'bz;

    always @(negedge CLK) begin
        if (nWE === 1'b0) sram[Address] = IO;
        if (nWE2 === 1'b0) sram2 = IO2;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        if (nRST) begin
            check("we_oe_exclusive", nWE | nOE, 1);
            if (!nWE) check("io_wdata", IO, exp_wdata);
            if (busy) check("addr_stable", Address, exp_addr);
            check("ack_overlap", rd_ack & wr_ack, 0);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        mon();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    function automatic logic [17:0] pick_addr();
        int r = $urandom_range(0, 5);
        case (r)
            0:       return 18'h00000;
            1:       return 18'h3FFFF;
            2, 3:    return 18'($urandom_range(0, 15));
            default: return 18'h3FFF0 + 18'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [15:0] pick_data();
        int r = $urandom_range(0, 3);
        case (r)
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    // One read, one write, or both at once; expectations come from ref_mem and m_last_wr.
    task automatic do_ops(input bit dr, input bit dw, input logic [17:0] ra,
                          input logic [17:0] wa, input logic [15:0] wd);
        bit          rd_pend = dr;
        bit          wr_pend = dw;
        bit          val_pend = dr;
        bit          first = dr && dw;
        bit          exp_first_rd = m_last_wr;
        int          n = 0;
        int          ack_cyc = 0;
        logic [15:0] exp_rd = 16'h0;
        rd_addr = ra;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = dr;
        wr_req  = dw;
        while ((rd_pend || wr_pend || val_pend) && n < 64) begin
            tick();
            n++;
            if (first && (rd_ack || wr_ack)) begin
                check("rr_order_rd_first", rd_ack, exp_first_rd);
                first = 0;
            end
            if (rd_ack) begin
                check("rd_ack_unexpected", rd_pend, 1);
                rd_pend   = 0;
                rd_req    = 0;
                rd_addr   = 18'($urandom);
                m_last_wr = 0;
                exp_addr  = ra;
                exp_rd    = ref_mem[ra];
                ack_cyc   = n;
            end
            if (wr_ack) begin
                check("wr_ack_unexpected", wr_pend, 1);
                wr_pend     = 0;
                wr_req      = 0;
                wr_addr     = 18'($urandom);
                wr_data     = 16'($urandom);
                m_last_wr   = 1;
                exp_addr    = wa;
                exp_wdata   = wd;
                ref_mem[wa] = wd;
            end
            if (rd_valid) begin
                check("rd_valid_unexpected", val_pend && !rd_pend, 1);
                check("rd_latency", n - ack_cyc, 1);
                check("rd_data", rd_data, exp_rd);
                val_pend = 0;
            end
        end
        check("op_timeout", rd_pend || wr_pend || val_pend, 0);
        wait_idle();
    endtask

    initial begin
        int          got, n, cnt_we, cnt_oe, cnt_busy, valid_at, k;
        logic [15:0] exp_rd;
        nRST = 1'b0;
        rd_req = 0; wr_req = 0; rd_addr = 0; wr_addr = 0; wr_data = 0;
        rd_req2 = 0; wr_req2 = 0; rd_addr2 = 0; wr_addr2 = 0; wr_data2 = 0;
        m_last_wr = 1; exp_addr = 0; exp_wdata = 0; exp_rd = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;

        check("rst_Address", Address, 0);
        check("rst_nWE", nWE, 1);
        check("rst_nOE", nOE, 1);
        check("rst_rd_ack", rd_ack, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        rd_req = 1;
        @(posedge CLK); #1;
        check("rst_no_ack", rd_ack, 0);
        check("rst_still_idle", busy, 0);
        rd_req = 0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // Directed write of 0xA5C3 to 0x00123 followed by its readback
        exp_addr = 18'h00123; exp_wdata = 16'hA5C3;
        wr_addr = 18'h00123; wr_data = 16'hA5C3; wr_req = 1;
        tick();
        check("w_ack", wr_ack, 1);
        check("w_busy", busy, 1);
        check("w_addr", Address, 18'h00123);
        check("w_setup_nwe", nWE, 1);
        check("w_setup_noe", nOE, 1);
        check("w_setup_io", IO, 16'hA5C3);
        wr_req = 0; wr_data = 16'h0000; wr_addr = 18'h0;
        tick();
        check("w_ack_pulse", wr_ack, 0);
        check("w_pulse_nwe", nWE, 0);
        check("w_pulse_io", IO, 16'hA5C3);
        tick();
        check("w_hold_nwe", nWE, 1);
        check("w_hold_io", IO, 16'hA5C3);
        check("w_hold_busy", busy, 1);
        tick();
        check("w_done_busy", busy, 0);
        check("sram_written", sram[18'h00123], 16'hA5C3);
        ref_mem[18'h00123] = 16'hA5C3;
        m_last_wr = 1;

        rd_addr = 18'h00123; rd_req = 1;
        tick();
        check("r_ack", rd_ack, 1);
        check("r_addr_noe", nOE, 0);
        check("r_addr_nwe", nWE, 1);
        check("r_no_valid_yet", rd_valid, 0);
        rd_req = 0; rd_addr = 18'h3FFFF;
        tick();
        check("r_valid", rd_valid, 1);
        check("r_data", rd_data, 16'hA5C3);
        check("r_ack_pulse", rd_ack, 0);
        check("r_turn_noe", nOE, 1);
        tick();
        check("r_valid_pulse", rd_valid, 0);
        check("r_done_busy", busy, 0);
        check("r_data_hold", rd_data, 16'hA5C3);
        m_last_wr = 0;

        // A write request raised and dropped while a read is in flight is never acked
        rd_addr = 18'h00123; rd_req = 1;
        tick();
        check("busy_rd_ack", rd_ack, 1);
        rd_req = 0; wr_req = 1; wr_addr = 18'h00001; wr_data = 16'h1111;
        tick();
        check("busy_rd_data", rd_data, 16'hA5C3);
        wr_req = 0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wr_ack) k++;
        end
        check("held_off_no_ack", k, 0);
        m_last_wr = 0;

        // Reset in the middle of the write pulse
        exp_addr = 18'h15555; exp_wdata = 16'h3C3C;
        wr_addr = 18'h15555; wr_data = 16'h3C3C; wr_req = 1;
        tick();
        check("mid_rst_wr_ack", wr_ack, 1);
        wr_req = 0;
        tick();
        check("mid_rst_pulse", nWE, 0);
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        check("async_rst_nWE", nWE, 1);
        check("async_rst_nOE", nOE, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_wr_ack", wr_ack, 0);
        check("async_rst_Address", Address, 0);
        check("async_rst_rd_valid", rd_valid, 0);
        ref_mem[18'h15555] = 16'h3C3C;
        m_last_wr = 1;

        // Both requests pending out of reset: read first, then strict alternation
        rd_addr = 18'h00200; wr_addr = 18'h00200; wr_data = 16'hC001;
        rd_req = 1; wr_req = 1;
        @(posedge CLK); #1;
        check("rst_hold_acks", rd_ack | wr_ack, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        check("first_edge_rd_ack", rd_ack, 1);
        got = 0; n = 0;
        while (got < 4 && n < 80) begin
            if (rd_ack || wr_ack) begin
                check("arb_ack_overlap", rd_ack & wr_ack, 0);
                check("arb_grant_is_rd", rd_ack, (got % 2) == 0);
                got++;
                if (rd_ack) begin
                    exp_addr = 18'h00200;
                    exp_rd   = ref_mem[18'h00200];
                end
                if (wr_ack) begin
                    exp_addr  = 18'h00200;
                    exp_wdata = wr_data;
                    ref_mem[18'h00200] = wr_data;
                    wr_data = wr_data + 16'h1111;
                end
                if (got == 4) begin
                    rd_req = 0;
                    wr_req = 0;
                end
            end
            if (rd_valid) check("arb_rd_data", rd_data, exp_rd);
            if (got < 4) begin
                tick();
                n++;
            end
        end
        check("arb_grants", got, 4);
        m_last_wr = 1;
        wait_idle();

        // Address and data extremes
        do_ops(0, 1, 18'h0, 18'h00000, 16'hFFFF);
        do_ops(0, 1, 18'h0, 18'h3FFFF, 16'h0000);
        do_ops(1, 0, 18'h00000, 18'h0, 16'h0);
        do_ops(1, 0, 18'h3FFFF, 18'h0, 16'h0);
        do_ops(0, 1, 18'h0, 18'h00000, 16'h0000);
        do_ops(0, 1, 18'h0, 18'h3FFFF, 16'hFFFF);
        do_ops(1, 1, 18'h00000, 18'h3FFFF, 16'h1234);
        do_ops(1, 1, 18'h3FFFF, 18'h00000, 16'hFEDC);
        do_ops(1, 0, 18'h00000, 18'h0, 16'h0);

        for (int i = 0; i < 1000; i++) begin
            k = $urandom_range(0, 2);
            do_ops(k != 1, k != 0, pick_addr(), pick_addr(), pick_data());
        end

        // RD_WAIT=3 / WR_PULSE=2 instance: strobe widths and occupancy
        wr_addr2 = 18'h0ABCD; wr_data2 = 16'h6E6E; wr_req2 = 1;
        tick();
        check("d2_wr_ack", wr_ack2, 1);
        wr_req2 = 0;
        cnt_we = 0; cnt_busy = 0;
        for (int i = 0; i < 10; i++) begin
            if (!nWE2) begin
                cnt_we++;
                check("d2_wr_io", IO2, 16'h6E6E);
            end
            if (busy2) cnt_busy++;
            tick();
        end
        check("d2_nwe_low_cycles", cnt_we, 2);
        check("d2_wr_busy_cycles", cnt_busy, 4);

        rd_addr2 = 18'h0ABCD; rd_req2 = 1;
        tick();
        check("d2_rd_ack", rd_ack2, 1);
        rd_req2 = 0;
        cnt_oe = 0; cnt_busy = 0; cnt_we = 0; valid_at = -1;
        for (int i = 0; i < 10; i++) begin
            if (!nOE2) cnt_oe++;
            if (!nWE2) cnt_we++;
            if (busy2) cnt_busy++;
            if (rd_valid2) begin
                valid_at = i;
                check("d2_rd_data", rd_data2, 16'h6E6E);
            end
            tick();
        end
        check("d2_noe_low_cycles", cnt_oe, 3);
        check("d2_rd_nwe_low", cnt_we, 0);
        check("d2_rd_busy_cycles", cnt_busy, 4);
        check("d2_rd_valid_at", valid_at, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
